vbs_mv_select: RTL and testbench

- Consumer end of the variable-block-size SAD datapath.
- Accepts one set of 41 partition SADs per candidate search position, emitted by the SAD-array/aggregation stage.
- Tracks, per partition, the minimum SAD and the motion vector that produced it over a full raster search window.
- Reports all 41 best (SAD, MV) pairs to mode decision when the window completes.

---
 rtl/vbs_me_pkg.sv | 29 ++
 rtl/vbs_min_cell.sv | 90 +++++++++
 rtl/vbs_mv_select.sv | 129 ++++++++++++
 tb/tb_vbs_mv_select.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vbs_me_pkg.sv
// Shared types and constants for the variable-block-size motion-vector selector.
// Partition index map, default widths and the selector FSM state encoding.
package vbs_me_pkg;

    localparam int NUM_PART = 41;

    localparam int SAD_WIDTH_DEF = 16;
    localparam int SR_DEF        = 16;
    localparam int MV_WIDTH_DEF  = $clog2(SR_DEF) + 1;

    // First index of each partition group inside the flattened SAD bus.
    localparam int P4X4_BASE   = 0;
    localparam int P4X8_BASE   = 16;
    localparam int P8X4_BASE   = 24;
    localparam int P8X8_BASE   = 32;
    localparam int P16X8_BASE  = 36;
    localparam int P8X16_BASE  = 38;
    localparam int P16X16_BASE = 40;

    typedef logic [SAD_WIDTH_DEF-1:0]       sad_t;
    typedef logic signed [MV_WIDTH_DEF-1:0] mv_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/vbs_min_cell.sv
// One partition's running-minimum tracker: best SAD and the MV that produced it.
// With VBS_MVCOST_EN the comparison uses SAD plus an MV penalty held in best_cost.
module vbs_min_cell
    import vbs_me_pkg::*;
#(
    parameter int SAD_WIDTH = 16,
    parameter int MV_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 upd,
    input  logic [SAD_WIDTH-1:0] sad_in,
    input  logic [MV_WIDTH-1:0]  cur_mvx,
    input  logic [MV_WIDTH-1:0]  cur_mvy,
`ifdef VBS_MVCOST_EN
    input  logic [SAD_WIDTH:0]   mv_pen,
`endif
    output logic [SAD_WIDTH-1:0] best_sad,
    output logic [MV_WIDTH-1:0]  best_mvx,
    output logic [MV_WIDTH-1:0]  best_mvy
);

    logic [SAD_WIDTH-1:0] best_sad_q, best_sad_d;
    logic [MV_WIDTH-1:0]  best_mvx_q, best_mvx_d;
    logic [MV_WIDTH-1:0]  best_mvy_q, best_mvy_d;
    logic                 win;

`ifdef VBS_MVCOST_EN
    logic [SAD_WIDTH:0]   best_cost_q, best_cost_d;
    logic [SAD_WIDTH+1:0] cost_sum;
    logic [SAD_WIDTH:0]   cost;

    always_comb begin
        cost_sum = {2'b00, sad_in} + {1'b0, mv_pen};
        cost     = cost_sum[SAD_WIDTH+1] ? '1 : cost_sum[SAD_WIDTH:0];
        win      = cost < best_cost_q;
    end
`else
    assign win = sad_in < best_sad_q;
`endif

    always_comb begin
        best_sad_d = best_sad_q;
        best_mvx_d = best_mvx_q;
        best_mvy_d = best_mvy_q;
`ifdef VBS_MVCOST_EN
        best_cost_d = best_cost_q;
`endif
        if (clear) begin
            best_sad_d = '1;
            best_mvx_d = '0;
            best_mvy_d = '0;
`ifdef VBS_MVCOST_EN
            best_cost_d = '1;
`endif
        end else if (upd && win) begin
            // Strict compare: on a tie the earlier raster candidate is kept.
            best_sad_d = sad_in;
            best_mvx_d = cur_mvx;
            best_mvy_d = cur_mvy;
`ifdef VBS_MVCOST_EN
            best_cost_d = cost;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_sad_q <= '1;
            best_mvx_q <= '0;
            best_mvy_q <= '0;
`ifdef VBS_MVCOST_EN
            best_cost_q <= '1;
`endif
        end else begin
            best_sad_q <= best_sad_d;
            best_mvx_q <= best_mvx_d;
            best_mvy_q <= best_mvy_d;
`ifdef VBS_MVCOST_EN
            best_cost_q <= best_cost_d;
`endif
        end
    end

    assign best_sad = best_sad_q;
    assign best_mvx = best_mvx_q;
    assign best_mvy = best_mvy_q;

endmodule

// File: rtl/vbs_mv_select.sv
// Per-partition best (SAD, MV) selection over a full raster search window.
// Optional MV-cost weighting is enabled by defining VBS_MVCOST_EN.
module vbs_mv_select
    import vbs_me_pkg::*;
#(
    parameter int SAD_WIDTH = 16,
    parameter int SR        = 16,
`ifdef VBS_MVCOST_EN
    parameter int LAMBDA_SHIFT = 2,
`endif
    localparam int MV_WIDTH = $clog2(SR) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           sad_valid,
    input  logic [NUM_PART*SAD_WIDTH-1:0]  sad_in,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_PART*SAD_WIDTH-1:0]  best_sad,
    output logic [NUM_PART*MV_WIDTH-1:0]   best_mvx,
    output logic [NUM_PART*MV_WIDTH-1:0]   best_mvy
);

    localparam logic signed [MV_WIDTH-1:0] MV_MIN = MV_WIDTH'(-SR);
    localparam logic signed [MV_WIDTH-1:0] MV_MAX = MV_WIDTH'(SR - 1);

    state_e                      state_q, state_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic signed [MV_WIDTH-1:0]  cur_mvx_q, cur_mvx_d;
    logic signed [MV_WIDTH-1:0]  cur_mvy_q, cur_mvy_d;
    logic                        clear;
    logic                        accept;

    always_comb begin
        state_d   = state_q;
        cur_mvx_d = cur_mvx_q;
        cur_mvy_d = cur_mvy_q;
        clear     = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SEARCH;
                    clear     = 1'b1;
                    cur_mvx_d = MV_MIN;
                    cur_mvy_d = MV_MIN;
                end
            end
            SEARCH: begin
                if (sad_valid) begin
                    accept = 1'b1;
                    if (cur_mvx_q == MV_MAX) begin
                        cur_mvx_d = MV_MIN;
                        if (cur_mvy_q == MV_MAX) begin
                            cur_mvy_d = MV_MIN;
                            state_d   = DONE;
                        end else begin
                            cur_mvy_d = cur_mvy_q + MV_WIDTH'(1);
                        end
                    end else begin
                        cur_mvx_d = cur_mvx_q + MV_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SEARCH);
        done_d = (state_q == SEARCH) && (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cur_mvx_q <= MV_MIN;
            cur_mvy_q <= MV_MIN;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cur_mvx_q <= cur_mvx_d;
            cur_mvy_q <= cur_mvy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

`ifdef VBS_MVCOST_EN
    // Penalty is shared by all partitions since it depends only on the MV.
    logic [MV_WIDTH-1:0] abs_x, abs_y;
    logic [MV_WIDTH:0]   mv_sum;
    logic [63:0]         pen_wide;
    logic [SAD_WIDTH:0]  mv_pen;

    always_comb begin
        abs_x    = cur_mvx_q[MV_WIDTH-1] ? (~cur_mvx_q + MV_WIDTH'(1)) : cur_mvx_q;
        abs_y    = cur_mvy_q[MV_WIDTH-1] ? (~cur_mvy_q + MV_WIDTH'(1)) : cur_mvy_q;
        mv_sum   = {1'b0, abs_x} + {1'b0, abs_y};
        pen_wide = 64'(mv_sum) << LAMBDA_SHIFT;
        mv_pen   = (|(pen_wide >> (SAD_WIDTH + 1))) ? '1 : pen_wide[SAD_WIDTH:0];
    end
`endif

    for (genvar p = 0; p < NUM_PART; p++) begin : g_cell
        vbs_min_cell #(
            .SAD_WIDTH (SAD_WIDTH),
            .MV_WIDTH  (MV_WIDTH)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .upd      (accept),
            .sad_in   (sad_in[p*SAD_WIDTH +: SAD_WIDTH]),
            .cur_mvx  (cur_mvx_q),
            .cur_mvy  (cur_mvy_q),
`ifdef VBS_MVCOST_EN
            .mv_pen   (mv_pen),
`endif
            .best_sad (best_sad[p*SAD_WIDTH +: SAD_WIDTH]),
            .best_mvx (best_mvx[p*MV_WIDTH +: MV_WIDTH]),
            .best_mvy (best_mvy[p*MV_WIDTH +: MV_WIDTH])
        );
    end

endmodule

// File: tb/tb_vbs_mv_select.sv
// Self-checking bench for vbs_mv_select with SR=2 (16 candidates per window).
// Expected winners are computed from the stimulus table and queued before each window.
module tb_vbs_mv_select;

    localparam int SW = 16;
    localparam int SR = 2;
    localparam int MW = 2;
    localparam int NP = 41;
    localparam int NC = (2 * SR) * (2 * SR);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 sad_valid;
    logic [NP*SW-1:0]     sad_in;
    logic                 busy;
    logic                 done;
    logic [NP*SW-1:0]     best_sad;
    logic [NP*MW-1:0]     best_mvx;
    logic [NP*MW-1:0]     best_mvy;

    vbs_mv_select #(.SAD_WIDTH(SW), .SR(SR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sad_valid (sad_valid),
        .sad_in    (sad_in),
        .busy      (busy),
        .done      (done),
        .best_sad  (best_sad),
        .best_mvx  (best_mvx),
        .best_mvy  (best_mvy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    part;
        logic [SW-1:0]         sad;
        logic signed [MW-1:0]  mvx;
        logic signed [MW-1:0]  mvy;
    } exp_t;

    exp_t          sb[$];
    int            stim [NC][NP];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic int mvx_of(int k);
        return (k % (2 * SR)) - SR;
    endfunction

    function automatic int mvy_of(int k);
        return (k / (2 * SR)) - SR;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int cost_of(int s, int k);
`ifdef VBS_MVCOST_EN
        int c;
        c = s + ((iabs(mvx_of(k)) + iabs(mvy_of(k))) << 2);
        return (c > 32'h1FFFF) ? 32'h1FFFF : c;
`else
        return s + 0 * iabs(k);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        for (int p = 0; p < NP; p++) begin
            int   best_c;
            exp_t e;
`ifdef VBS_MVCOST_EN
            best_c = 32'h1FFFF;
`else
            best_c = 32'hFFFF;
`endif
            e.part = p;
            e.sad  = '1;
            e.mvx  = '0;
            e.mvy  = '0;
            for (int k = 0; k < NC; k++) begin
                if (cost_of(stim[k][p], k) < best_c) begin
                    best_c = cost_of(stim[k][p], k);
                    e.sad  = SW'(stim[k][p]);
                    e.mvx  = MW'(mvx_of(k));
                    e.mvy  = MW'(mvy_of(k));
                end
            end
            sb.push_back(e);
        end
    endtask

    task automatic check_results(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (best_sad[e.part*SW +: SW] !== e.sad)
                $display("FAIL %s best_sad[%0d]: got %0d expected %0d", tag, e.part, best_sad[e.part*SW +: SW], e.sad);
            else n_pass++;
            n_checks++;
            if (best_mvx[e.part*MW +: MW] !== e.mvx)
                $display("FAIL %s best_mvx[%0d]: got %b expected %b", tag, e.part, best_mvx[e.part*MW +: MW], e.mvx);
            else n_pass++;
            n_checks++;
            if (best_mvy[e.part*MW +: MW] !== e.mvy)
                $display("FAIL %s best_mvy[%0d]: got %b expected %b", tag, e.part, best_mvy[e.part*MW +: MW], e.mvy);
            else n_pass++;
        end
    endtask

    task automatic run_window(input string tag, input bit gaps, input bit valid_on_start);
        int d0;
        d0 = done_cnt;
        push_expected();
        // A zero SAD on the start cycle would win everywhere if it were not dropped.
        start     = 1'b1;
        sad_valid = valid_on_start;
        sad_in    = '0;
        tick();
        start     = 1'b0;
        sad_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b expected 1", tag, busy);
        else n_pass++;
        for (int k = 0; k < NC; k++) begin
            sad_valid = 1'b1;
            for (int p = 0; p < NP; p++) sad_in[p*SW +: SW] = SW'(stim[k][p]);
            tick();
            if (gaps && k < NC - 1) begin
                sad_valid = 1'b0;
                sad_in    = '0;
                for (int g = 0; g < 3; g++) begin
                    start = (g == 1);
                    tick();
                end
                start = 1'b0;
            end
        end
        sad_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1) $display("FAIL %s done_after_last: got %b expected 1", tag, done);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b expected 0", tag, busy);
        else n_pass++;
        sad_valid = 1'b1;
        sad_in    = '0;
        tick();
        sad_valid = 1'b0;
        n_checks++;
        if (done !== 1'b0) $display("FAIL %s done_width: got %b expected 0", tag, done);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 !== 1) $display("FAIL %s done_pulses: got %0d expected 1", tag, done_cnt - d0);
        else n_pass++;
        check_results(tag);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        sad_valid = 1'b0;
        sad_in    = '0;
        tick();
        tick();
        rst       = 1'b0;
        sad_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        sad_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset done: got %b expected 0", done);
        else n_pass++;
        n_checks++;
        if (best_sad !== {NP*SW{1'b1}}) $display("FAIL reset best_sad: got %h expected all ones", best_sad);
        else n_pass++;
        n_checks++;
        if (best_mvx !== {NP*MW{1'b0}} || best_mvy !== {NP*MW{1'b0}})
            $display("FAIL reset mv: got %h/%h expected 0/0", best_mvx, best_mvy);
        else n_pass++;
    endtask

    task automatic test_single_min();
        for (int k = 0; k < NC; k++)
            for (int p = 0; p < NP; p++) stim[k][p] = (k == 7) ? 7 : 100;
        run_window("single_min", 1'b0, 1'b0);
    endtask

    task automatic test_partition_distinct();
        for (int k = 0; k < NC; k++)
            for (int p = 0; p < NP; p++) stim[k][p] = (k == p % NC) ? 0 : 500;
        run_window("partition", 1'b0, 1'b0);
    endtask

    task automatic test_ties();
        for (int k = 0; k < NC; k++)
            for (int p = 0; p < NP; p++) stim[k][p] = 50;
        run_window("ties", 1'b0, 1'b1);
    endtask

    task automatic test_gaps();
        for (int k = 0; k < NC; k++)
            for (int p = 0; p < NP; p++) stim[k][p] = (k == p % NC) ? 0 : 500;
        run_window("gaps", 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        int d0;
        d0        = done_cnt;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        sad_valid = 1'b1;
        for (int p = 0; p < NP; p++) sad_in[p*SW +: SW] = SW'(1);
        for (int k = 0; k < 8; k++) tick();
        sad_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort busy: got %b expected 0", busy);
        else n_pass++;
        n_checks++;
        if (best_sad !== {NP*SW{1'b1}}) $display("FAIL abort best_sad: got %h expected all ones", best_sad);
        else n_pass++;
        tick();
        n_checks++;
        if (done_cnt !== d0) $display("FAIL abort done_pulses: got %0d expected %0d", done_cnt, d0);
        else n_pass++;
        // Equal SADs at (0,0) and (1,1); both modes must prefer (0,0).
        for (int k = 0; k < NC; k++)
            for (int p = 0; p < NP; p++) stim[k][p] = (k == 10 || k == 15) ? 20 : 100;
        run_window("after_abort", 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        sad_valid = 1'b0;
        sad_in    = '0;
        test_reset();
        test_single_min();
        test_partition_distinct();
        test_ties();
        test_gaps();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
